gray_counter: RTL and testbench

GRAY_COUNTER -- requirements
Module: gray_counter

---
 rtl/gray_counter.sv | 92 +++++++++
 tb/tb_gray_counter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code view and a valid/ready output handshake.
// Define GRAY_COUNTER_SAT_EN to saturate at the end values instead of wrapping.
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             out_valid
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_q,   bin_d;
  logic [WIDTH-1:0] gray_q,  gray_d;
  logic             wrap_q,  wrap_d;
  logic             valid_q, valid_d;
  logic             adv;
  logic             at_top;
  logic             at_bot;

  assign adv    = en & (~valid_q | out_ready);
  assign at_top = (bin_q == CNT_MAX);
  assign at_bot = (bin_q == '0);

  always_comb begin
    bin_d   = bin_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;
    if (load) begin
      bin_d   = load_bin;
      valid_d = 1'b1;
    end else if (adv) begin
      valid_d = 1'b1;
      if (up) begin
        if (at_top) begin
`ifdef GRAY_COUNTER_SAT_EN
          bin_d  = bin_q;
`else
          bin_d  = '0;
          wrap_d = 1'b1;
`endif
        end else begin
          bin_d = bin_q + CNT_ONE;
        end
      end else begin
        if (at_bot) begin
`ifdef GRAY_COUNTER_SAT_EN
          bin_d  = bin_q;
`else
          bin_d  = CNT_MAX;
          wrap_d = 1'b1;
`endif
        end else begin
          bin_d = bin_q - CNT_ONE;
        end
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    // Gray is derived from the next binary value so both registers move on the same edge.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= '0;
      gray_q  <= '0;
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      wrap_q  <= wrap_d;
      valid_q <= valid_d;
    end
  end

  assign bin       = bin_q;
  assign gray      = gray_q;
  assign wrap      = wrap_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: stimulus pushes model predictions, a negedge monitor compares.
// Honours GRAY_COUNTER_SAT_EN in the reference model.
module tb_gray_counter;
  localparam int W    = 4;
  localparam int MODV = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0, up = 1'b1, load = 1'b0, out_ready = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic [W-1:0] bin, gray;
  logic         wrap, out_valid;

  gray_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin),
    .out_ready(out_ready), .bin(bin), .gray(gray), .wrap(wrap), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;
    logic         valid;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int unsigned m_bin   = 0;
  bit          m_valid = 0;
  bit          m_wrap  = 0;

  // Gray bit i toggles every 2^(i+1) counts, offset by 2^i: pure arithmetic definition.
  function automatic logic [W-1:0] gray_of(int unsigned v);
    logic [W-1:0] g;
    for (int i = 0; i < W; i++) g[i] = ((v + (1 << i)) >> (i + 1)) & 1;
    return g;
  endfunction

  task automatic model_step(bit r, bit e, bit u, bit l, int unsigned lb, bit rdy);
    if (r) begin
      m_bin = 0; m_valid = 0; m_wrap = 0;
    end else if (l) begin
      m_bin = lb; m_valid = 1; m_wrap = 0;
    end else if (e && (!m_valid || rdy)) begin
      m_valid = 1;
      m_wrap  = 0;
      if (u && m_bin == MODV - 1) begin
`ifndef GRAY_COUNTER_SAT_EN
        m_bin = 0; m_wrap = 1;
`endif
      end else if (!u && m_bin == 0) begin
`ifndef GRAY_COUNTER_SAT_EN
        m_bin = MODV - 1; m_wrap = 1;
`endif
      end else begin
        m_bin = u ? m_bin + 1 : m_bin - 1;
      end
    end else begin
      m_wrap = 0;
      if (m_valid && rdy) m_valid = 0;
    end
  endtask

  task automatic drive(bit r, bit e, bit u, bit l, int unsigned lb, bit rdy);
    exp_t x;
    rst = r; en = e; up = u; load = l; load_bin = lb[W-1:0]; out_ready = rdy;
    model_step(r, e, u, l, lb, rdy);
    x.bin   = m_bin[W-1:0];
    x.gray  = gray_of(m_bin);
    x.wrap  = m_wrap;
    x.valid = m_valid;
    @(posedge clk);
    exp_q.push_back(x);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      n_cmp++;
      if (bin !== x.bin || gray !== x.gray || wrap !== x.wrap || out_valid !== x.valid) begin
        n_err++;
        $display("FAIL cycle_check t=%0t: got bin=%h gray=%b wrap=%b valid=%b, expected bin=%h gray=%b wrap=%b valid=%b",
                 $time, bin, gray, wrap, out_valid, x.bin, x.gray, x.wrap, x.valid);
      end
    end
  end

  initial begin
    #1;
    drive(1, 0, 1, 0, 0, 0);
    // Full up-count with wrap on the last step.
    for (int i = 0; i < 16; i++) drive(0, 1, 1, 0, 0, 1);
    // Down from zero wraps to 15, then 14.
    drive(1, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 0, 1);
    // Backpressure from bin=3 with out_valid low.
    drive(0, 0, 1, 1, 3, 1);
    drive(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 1);
    // Load wins over en under backpressure.
    drive(0, 1, 1, 1, 10, 0);
    drive(0, 1, 1, 0, 0, 0);
    // Reset wins over load and en.
    drive(0, 0, 1, 1, 9, 0);
    drive(1, 1, 1, 1, 5, 0);
    // Saturation/wrap at the top after a load of 15.
    drive(0, 0, 1, 1, 15, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 2000; i++)
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7), $urandom_range(0, 1),
            ($urandom_range(0, 9) == 0), $urandom_range(0, MODV - 1), ($urandom_range(0, 9) < 6));
    drive(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
